// File: rtl/decode_pkg.sv
// Shared definitions for the decode stage: opcode encodings, ALUOp codes,
// the ID/EX control bundle and the opcode-to-control decoder.
package decode_pkg;

  localparam logic [2:0] OP_RTYPE = 3'b000;
  localparam logic [2:0] OP_LW    = 3'b001;
  localparam logic [2:0] OP_SW    = 3'b010;
  localparam logic [2:0] OP_BEQ   = 3'b011;
  localparam logic [2:0] OP_ADDI  = 3'b100;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  // Field order is the bit order of ex_ctrl_o, MSB first.
  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic [1:0] alu_op;
    logic       spare;
  } ctrl_t;

  // Opcodes 101..111 fall through to an all-zero bundle (NOP).
  function automatic ctrl_t decode_ctrl(input logic [2:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      OP_RTYPE: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
        c.alu_op    = ALU_FUNCT;
      end
      OP_LW: begin
        c.alu_src    = 1'b1;
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
        c.mem_read   = 1'b1;
        c.alu_op     = ALU_ADD;
      end
      OP_SW: begin
        c.alu_src   = 1'b1;
        c.mem_write = 1'b1;
        c.alu_op    = ALU_ADD;
      end
      OP_BEQ: begin
        c.branch = 1'b1;
        c.alu_op = ALU_SUB;
      end
      OP_ADDI: begin
        c.alu_src   = 1'b1;
        c.reg_write = 1'b1;
        c.alu_op    = ALU_ADD;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Instructions whose rt field is a source operand rather than a destination.
  function automatic logic uses_rt(input logic [2:0] op);
    return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ);
  endfunction

endpackage

// File: rtl/decode_regfile.sv
// Register file for the decode stage: two combinational read ports, one
// write port committed at the clock edge, asynchronous clear of every entry.
// Optional macro DECODE_BYPASS_EN: a same-cycle write is forwarded to the
// read ports; without it reads return the pre-write array contents.
module decode_regfile
  import decode_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we_i,
  input  logic [REG_ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic [REG_ADDR_W-1:0] raddr1_i,
  input  logic [REG_ADDR_W-1:0] raddr2_i,
  output logic [DATA_W-1:0]     rdata1_o,
  output logic [DATA_W-1:0]     rdata2_o
);

  localparam int NUM_REGS = 2 ** REG_ADDR_W;

  logic [DATA_W-1:0] regs_q [NUM_REGS];

  // Array storage: cleared on reset, one write per cycle from write-back.
  // NOTE: resetting every entry forces this array into flip-flops (no SRAM
  // macro supports an async clear); that is intended for this small file.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

`ifdef DECODE_BYPASS_EN
  // Write-through: a register written this cycle is seen by the reader now.
  assign rdata1_o = (we_i && (waddr_i == raddr1_i)) ? wdata_i : regs_q[raddr1_i];
  assign rdata2_o = (we_i && (waddr_i == raddr2_i)) ? wdata_i : regs_q[raddr2_i];
`else
  // Plain read of the stored value; forwarding downstream covers the gap.
  assign rdata1_o = regs_q[raddr1_i];
  assign rdata2_o = regs_q[raddr2_i];
`endif

endmodule

// File: rtl/pipelined_decode_unit.sv
// Decode stage of the in-order pipeline: field extraction, control decode,
// immediate sign-extension, load-use hazard detection and the ID/EX
// register with flush / hold / bubble control.
// Optional macro DECODE_BYPASS_EN enables write-through in decode_regfile.
module pipelined_decode_unit
  import decode_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int INSTR_W    = 16,
  parameter int REG_ADDR_W = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid_i,
  input  logic [INSTR_W-1:0]    instruction,
  output logic                  stall_o,
  input  logic                  flush_i,
  input  logic                  ex_hold_i,
  input  logic                  wb_we_i,
  input  logic [REG_ADDR_W-1:0] wb_addr_i,
  input  logic [DATA_W-1:0]     wb_data_i,
  output logic                  ex_valid_o,
  output logic [DATA_W-1:0]     ex_rd1_o,
  output logic [DATA_W-1:0]     ex_rd2_o,
  output logic [DATA_W-1:0]     ex_imm_o,
  output logic [REG_ADDR_W-1:0] ex_rs_o,
  output logic [REG_ADDR_W-1:0] ex_rt_o,
  output logic [REG_ADDR_W-1:0] ex_wreg_o,
  output logic [9:0]            ex_ctrl_o
);

  localparam int IMM_W = INSTR_W - 3 - 2 * REG_ADDR_W;

  // Instruction fields
  logic [2:0]            opcode;
  logic [REG_ADDR_W-1:0] rs;
  logic [REG_ADDR_W-1:0] rt;
  logic [REG_ADDR_W-1:0] rd;
  logic [IMM_W-1:0]      imm;
  logic [DATA_W-1:0]     imm_ext;
  logic [DATA_W-1:0]     rd1;
  logic [DATA_W-1:0]     rd2;
  ctrl_t                 ctrl_dec;
  logic [REG_ADDR_W-1:0] wreg_dec;
  logic                  hazard;

  assign opcode   = instruction[INSTR_W-1 -: 3];
  assign rs       = instruction[INSTR_W-4 -: REG_ADDR_W];
  assign rt       = instruction[INSTR_W-4-REG_ADDR_W -: REG_ADDR_W];
  assign imm      = instruction[IMM_W-1:0];
  assign rd       = imm[IMM_W-1 -: REG_ADDR_W];
  assign imm_ext  = {{(DATA_W - IMM_W){imm[IMM_W-1]}}, imm};
  assign ctrl_dec = decode_ctrl(opcode);
  assign wreg_dec = ctrl_dec.reg_dst ? rd : rt;

  // ID/EX state
  logic                  ex_valid_q, ex_valid_d;
  ctrl_t                 ex_ctrl_q,  ex_ctrl_d;
  logic [DATA_W-1:0]     ex_rd1_q,   ex_rd1_d;
  logic [DATA_W-1:0]     ex_rd2_q,   ex_rd2_d;
  logic [DATA_W-1:0]     ex_imm_q,   ex_imm_d;
  logic [REG_ADDR_W-1:0] ex_rs_q,    ex_rs_d;
  logic [REG_ADDR_W-1:0] ex_rt_q,    ex_rt_d;
  logic [REG_ADDR_W-1:0] ex_wreg_q,  ex_wreg_d;

  decode_regfile #(
    .DATA_W     (DATA_W),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .we_i     (wb_we_i),
    .waddr_i  (wb_addr_i),
    .wdata_i  (wb_data_i),
    .raddr1_i (rs),
    .raddr2_i (rt),
    .rdata1_o (rd1),
    .rdata2_o (rd2)
  );

  // A load in EX whose destination is a source of the instruction in ID.
  assign hazard = ex_valid_q & ex_ctrl_q.mem_read & id_valid_i &
                  ((ex_wreg_q == rs) | (uses_rt(opcode) & (ex_wreg_q == rt)));

  assign stall_o = hazard | ex_hold_i;

  // Next ID/EX contents: flush, then hold, then hazard bubble, then load.
  // NOTE: every _d starts from its current _q so each path through the
  // if/else assigns all of them and no latch is inferred.
  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_ctrl_d  = ex_ctrl_q;
    ex_rd1_d   = ex_rd1_q;
    ex_rd2_d   = ex_rd2_q;
    ex_imm_d   = ex_imm_q;
    ex_rs_d    = ex_rs_q;
    ex_rt_d    = ex_rt_q;
    ex_wreg_d  = ex_wreg_q;
    if (flush_i) begin
      ex_valid_d = 1'b0;
      ex_ctrl_d  = '0;
    end else if (ex_hold_i) begin
      ex_valid_d = ex_valid_q;
    end else if (hazard) begin
      ex_valid_d = 1'b0;
      ex_ctrl_d  = '0;
    end else begin
      ex_valid_d = id_valid_i;
      ex_ctrl_d  = id_valid_i ? ctrl_dec : '0;
      ex_rd1_d   = rd1;
      ex_rd2_d   = rd2;
      ex_imm_d   = imm_ext;
      ex_rs_d    = rs;
      ex_rt_d    = rt;
      ex_wreg_d  = wreg_dec;
    end
  end

  // ID/EX pipeline register.
  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q <= 1'b0;
      ex_ctrl_q  <= '0;
      ex_rd1_q   <= '0;
      ex_rd2_q   <= '0;
      ex_imm_q   <= '0;
      ex_rs_q    <= '0;
      ex_rt_q    <= '0;
      ex_wreg_q  <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_ctrl_q  <= ex_ctrl_d;
      ex_rd1_q   <= ex_rd1_d;
      ex_rd2_q   <= ex_rd2_d;
      ex_imm_q   <= ex_imm_d;
      ex_rs_q    <= ex_rs_d;
      ex_rt_q    <= ex_rt_d;
      ex_wreg_q  <= ex_wreg_d;
    end
  end

  assign ex_valid_o = ex_valid_q;
  assign ex_ctrl_o  = ex_ctrl_q;
  assign ex_rd1_o   = ex_rd1_q;
  assign ex_rd2_o   = ex_rd2_q;
  assign ex_imm_o   = ex_imm_q;
  assign ex_rs_o    = ex_rs_q;
  assign ex_rt_o    = ex_rt_q;
  assign ex_wreg_o  = ex_wreg_q;

endmodule

// File: doc/pipelined_decode_unit.md
# pipelined_decode_unit

Parametrised decode stage for the in-order MIPS-style pipeline. It holds the register file, decodes the 3-bit opcode into control signals and sign-extends the immediate. It also detects load-use hazards and registers the result into an ID/EX pipeline register with valid, stall, flush and hold control. It sits between the IF/ID register (fetch side) and the execute stage, with the write-back port fed from the WB stage.

## Interface
Parameters:
- DATA_W, 16, register/data width
- INSTR_W, 16, instruction width
- REG_ADDR_W, 3, register index width; NUM_REGS = 2**REG_ADDR_W

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- id_valid_i  in  1  IF/ID holds a real instruction
- instruction  in  INSTR_W  IF/ID instruction
- stall_o  out  1  hold IF/ID and PC this cycle
- flush_i  in  1  branch taken; squash the instruction being loaded into ID/EX
- ex_hold_i  in  1  execute stage cannot accept; freeze ID/EX
- wb_we_i  in  1  write-back enable
- wb_addr_i  in  REG_ADDR_W  write-back register
- wb_data_i  in  DATA_W  write-back data
- ex_valid_o  out  1  ID/EX contents valid
- ex_rd1_o, ex_rd2_o  out  DATA_W  operand values
- ex_imm_o  out  DATA_W  sign-extended immediate
- ex_rs_o, ex_rt_o, ex_wreg_o  out  REG_ADDR_W  source registers and selected destination
- ex_ctrl_o  out  10  {RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp[1:0], spare=0}

## Operation
- Fields: opcode = instruction[INSTR_W-1 -: 3]; rs = next REG_ADDR_W bits; rt = next REG_ADDR_W bits; imm = remaining IMM_W = INSTR_W-3-2*REG_ADDR_W bits. rd = top REG_ADDR_W bits of imm.
- Immediate: sign-extend imm[IMM_W-1] to DATA_W.
- Opcodes:
  - 000 R-type: RegDst, RegWrite, ALUOp=10
  - 001 LW: ALUSrc, MemtoReg, RegWrite, MemRead, ALUOp=00
  - 010 SW: ALUSrc, MemWrite, ALUOp=00
  - 011 BEQ: Branch, ALUOp=01
  - 100 ADDI: ALUSrc, RegWrite, ALUOp=00
  - 101–111: NOP, all control signals 0
- ex_wreg = RegDst ? rd : rt.
- Register file: 2 combinational read ports, 1 write port written at the clock edge when wb_we_i is high. Every register is writable.
- Load-use hazard: ex_valid_o & MemRead(ex_ctrl_o) & id_valid_i & (ex_wreg_o==rs | (uses_rt & ex_wreg_o==rt)), where uses_rt is true for R-type, SW and BEQ.
- stall_o = hazard | ex_hold_i.
- ID/EX update, in priority order:
  1. Reset clears the register.
  2. flush_i loads a bubble: ex_valid_o=0, control signals 0.
  3. ex_hold_i holds the register unchanged.
  4. hazard loads a bubble.
  5. Otherwise load the decoded instruction with ex_valid_o=id_valid_i. When id_valid_i=0, control signals are loaded as 0.

## Timing
- Reset values: all ID/EX outputs 0 and all registers 0 (asynchronous, on rst_n low). stall_o is 0 while ex_valid_o is 0 and ex_hold_i is 0.
- Latency: one cycle from IF/ID to ID/EX outputs. stall_o is combinational in the same cycle.
- A load-use stall inserts exactly one bubble. On the next cycle the load is in MEM, the hazard term drops and the instruction proceeds.
- flush_i together with ex_hold_i: flush wins and ID/EX becomes a bubble.
- wb write to the register being read in the same cycle: see Configuration.
- If rst_n is asserted mid-stall, the stall is dropped and the pipeline restarts empty.

## Configuration
- DECODE_BYPASS_EN defined: write-through bypass. If wb_we_i and wb_addr_i matches rs or rt, the read port returns wb_data_i in the same cycle.
- DECODE_BYPASS_EN undefined: reads return the pre-write array value. The WB stage or the forwarding unit must cover the one-cycle gap.

## Structure
- Package decode_pkg holds:
  - opcode localparams (OP_RTYPE … OP_ADDI)
  - ALUOp constants (ALU_ADD=00, ALU_SUB=01, ALU_FUNCT=10)
  - packed struct ctrl_t matching the ex_ctrl_o bit order
- Sub-module decode_regfile holds the register array, the asynchronous reset of the array and the bypass.
- Hazard detection, control decode and the ID/EX register stay in the top module.

## Test plan
- Reset: hold rst_n=0 mid-stream -> all outputs 0, stall_o=0; after release, a read of r5 returns 0x0000.
- ADDI r2←r1+(-1) with imm=7'h7F -> next cycle ex_imm_o=0xFFFF, ALUSrc=1, RegWrite=1, ex_wreg_o=2, ex_valid_o=1.
- LW r3 followed by R-type using rs=r3 -> stall_o=1 for exactly one cycle, one bubble (ex_valid_o=0), then the R-type appears with RegDst=1 and ALUOp=10.
- flush_i=1 while BEQ is in IF/ID -> ex_valid_o=0 next cycle, all control signals 0.
- ex_hold_i=1 for 3 cycles -> ID/EX unchanged and stall_o=1 throughout. The instruction advances on the cycle after the hold drops.
- wb_we_i=1, wb_addr_i=4, wb_data_i=0xBEEF with rs=4 in the same cycle -> ex_rd1_o=0xBEEF with DECODE_BYPASS_EN, the old value without it.
